// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader that writes a program image into the
// instruction memory write port. A frame is a 16-bit little-endian word count
// followed by that many 32-bit little-endian words.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that is verified in a CHK state before the frame is reported done.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; rx bytes ignored
// LEN_LO | waiting for word count bits 7:0
// LEN_HI | waiting for word count bits 15:8
// DATA   | assembling bytes into words, one imem write per fourth byte
// CHK    | (checksum build only) waiting for the XOR checksum byte
// DONE   | frame complete for one cycle, then back to IDLE

module imem_loader #(
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [15:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE
  } state_t;
`endif

  state_t      state, state_d;
  logic [15:0] len, len_d;
  logic [1:0]  lane, lane_d;
  logic [23:0] asm_word, asm_word_d;
  logic [31:0] tmo_cnt, tmo_cnt_d;
  logic [7:0]  chk, chk_d;
  logic [15:0] addr_d, wc_d;
  logic [31:0] data_d;
  logic        wren_d, busy_d, done_d, error_d;

  logic [15:0] len_full;
  logic [15:0] wc_inc;
  logic        tmo_hit;

  assign len_full = {rx_data, len[7:0]};
  assign wc_inc   = word_count + 16'd1;
  // The abort fires on the edge where the idle-cycle count would reach the limit.
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && !rx_valid &&
                    ((tmo_cnt + 32'd1) >= TIMEOUT_CYCLES);

  // Register every piece of loader state; reset aborts any frame in flight.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state       <= S_IDLE;
      len         <= '0;
      lane        <= '0;
      asm_word    <= '0;
      tmo_cnt     <= '0;
      chk         <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      word_count  <= '0;
    end else begin
      state       <= state_d;
      len         <= len_d;
      lane        <= lane_d;
      asm_word    <= asm_word_d;
      tmo_cnt     <= tmo_cnt_d;
      chk         <= chk_d;
      mem_address <= addr_d;
      mem_data    <= data_d;
      mem_wren    <= wren_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      word_count  <= wc_d;
    end
  end

  // Next-state and next-output logic for the frame parser.
  always_comb begin
    state_d    = state;
    len_d      = len;
    lane_d     = lane;
    asm_word_d = asm_word;
    tmo_cnt_d  = tmo_cnt;
    chk_d      = chk;
    addr_d     = mem_address;
    data_d     = mem_data;
    wren_d     = 1'b0;
    busy_d     = busy;
    done_d     = done;
    error_d    = error;
    wc_d       = word_count;

    // The inter-byte timer only runs while a frame is being received.
    if (state != S_IDLE && state != S_DONE) begin
      if (rx_valid || TIMEOUT_CYCLES == 0) tmo_cnt_d = '0;
      else                                 tmo_cnt_d = tmo_cnt + 32'd1;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LEN_LO;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          wc_d      = '0;
          tmo_cnt_d = '0;
          lane_d    = '0;
          chk_d     = '0;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          chk_d      = chk ^ rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          len_d  = len_full;
          chk_d  = chk ^ rx_data;
          lane_d = '0;
          if (len_full != 16'd0) begin
            state_d = S_DATA;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          chk_d  = chk ^ rx_data;
          lane_d = lane + 2'd1;
          case (lane)
            2'd0: asm_word_d[7:0]   = rx_data;
            2'd1: asm_word_d[15:8]  = rx_data;
            2'd2: asm_word_d[23:16] = rx_data;
            default: begin
              wren_d = 1'b1;
              data_d = {rx_data, asm_word};
              addr_d = BASE_ADDR + word_count;
              wc_d   = wc_inc;
              if (wc_inc == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = S_CHK;
`else
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
`endif
              end
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid) begin
          busy_d = 1'b0;
          if (rx_data == chk) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Inter-byte timeout: drop the frame and any partially assembled word.
    if ((state == S_LEN_LO || state == S_LEN_HI || state == S_DATA
`ifdef IMEM_LOADER_CHECKSUM_EN
         || state == S_CHK
`endif
        ) && tmo_hit) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      error_d   = 1'b1;
      done_d    = 1'b0;
      wren_d    = 1'b0;
      lane_d    = '0;
      tmo_cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Two instances: u0 (base 0000, 100-cycle
// timeout) and u1 (base FFFF, timeout disabled) share clock, reset and the
// byte stream; each has its own start. Write ports are logged on negedge.
`timescale 1ns/1ps

module tb_imem_loader;

  logic        clock = 1'b0;
  logic        clrn;
  logic        start0, start1;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic [15:0] a0, a1, wc0, wc1;
  logic [31:0] d0, d1;
  logic        w0, w1, b0, b1, dn0, dn1, e0, e1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  fb [0:15];
  logic [15:0] log0_a [0:31];
  logic [31:0] log0_d [0:31];
  logic [15:0] log1_a [0:31];
  logic [31:0] log1_d [0:31];
  int log0_n = 0;
  int log1_n = 0;
  int base;

  always #5 clock = ~clock;

  imem_loader #(.BASE_ADDR(16'h0000), .TIMEOUT_CYCLES(100)) u0 (
    .clock(clock), .clrn(clrn), .start(start0), .rx_valid(rx_valid),
    .rx_data(rx_data), .mem_address(a0), .mem_data(d0), .mem_wren(w0),
    .busy(b0), .done(dn0), .error(e0), .word_count(wc0));

  imem_loader #(.BASE_ADDR(16'hFFFF), .TIMEOUT_CYCLES(0)) u1 (
    .clock(clock), .clrn(clrn), .start(start1), .rx_valid(rx_valid),
    .rx_data(rx_data), .mem_address(a1), .mem_data(d1), .mem_wren(w1),
    .busy(b1), .done(dn1), .error(e1), .word_count(wc1));

  // Capture every imem write from both instances.
  always @(negedge clock) begin
    if (w0 === 1'b1 && log0_n < 32) begin
      log0_a[log0_n] = a0; log0_d[log0_n] = d0; log0_n = log0_n + 1;
    end
    if (w1 === 1'b1 && log1_n < 32) begin
      log1_a[log1_n] = a1; log1_d[log1_n] = d1; log1_n = log1_n + 1;
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Sends fb[0..n-1]; checksum build appends the XOR of those bytes.
  task automatic send_frame(input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      send_byte(fb[i]);
      x = x ^ fb[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0; start0 = 1'b0; start1 = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #1;
    tick(); tick();
    checks++; if ({b0, dn0, e0, w0} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: got %b want 0000", {b0, dn0, e0, w0}); end
    checks++; if ({a0, d0, wc0} !== 64'h0) begin errors++;
      $display("FAIL reset_regs: got %h want 0", {a0, d0, wc0}); end
    clrn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    base = log0_n;
    pulse_start(0);
    checks++; if ({b0, dn0} !== 2'b10) begin errors++;
      $display("FAIL basic_busy: got %b want 10", {b0, dn0}); end
    fb[0] = 8'h02; fb[1] = 8'h00;
    fb[2] = 8'h78; fb[3] = 8'h56; fb[4] = 8'h34; fb[5] = 8'h12;
    fb[6] = 8'hEF; fb[7] = 8'hBE; fb[8] = 8'hAD; fb[9] = 8'hDE;
    send_frame(10);
    checks++; if ({b0, dn0, e0} !== 3'b010) begin errors++;
      $display("FAIL basic_done: got %b want 010", {b0, dn0, e0}); end
    checks++; if (wc0 !== 16'd2) begin errors++;
      $display("FAIL basic_wc: got %h want 0002", wc0); end
    tick(); tick();
    checks++; if (dn0 !== 1'b1) begin errors++;
      $display("FAIL basic_done_hold: got %b want 1", dn0); end
    checks++; if (log0_n - base !== 2) begin errors++;
      $display("FAIL basic_nwrites: got %0d want 2", log0_n - base); end
    checks++; if ({log0_a[base], log0_d[base]} !== {16'h0000, 32'h12345678}) begin errors++;
      $display("FAIL basic_w0: got %h/%h want 0000/12345678", log0_a[base], log0_d[base]); end
    checks++; if ({log0_a[base+1], log0_d[base+1]} !== {16'h0001, 32'hDEADBEEF}) begin errors++;
      $display("FAIL basic_w1: got %h/%h want 0001/deadbeef", log0_a[base+1], log0_d[base+1]); end
    checks++; if ({a0, d0} !== {16'h0001, 32'hDEADBEEF}) begin errors++;
      $display("FAIL basic_hold: got %h/%h want 0001/deadbeef", a0, d0); end
  endtask

  task automatic test_len_zero();
    base = log0_n;
    pulse_start(0);
    fb[0] = 8'h00; fb[1] = 8'h00;
    send_frame(2);
    checks++; if ({b0, dn0, e0} !== 3'b010) begin errors++;
      $display("FAIL len0_done: got %b want 010", {b0, dn0, e0}); end
    checks++; if (wc0 !== 16'd0) begin errors++;
      $display("FAIL len0_wc: got %h want 0000", wc0); end
    tick(); tick();
    checks++; if (log0_n - base !== 0) begin errors++;
      $display("FAIL len0_nwrites: got %0d want 0", log0_n - base); end
  endtask

  task automatic test_wrap();
    base = log1_n;
    pulse_start(1);
    fb[0] = 8'h02; fb[1] = 8'h00;
    fb[2] = 8'h01; fb[3] = 8'h02; fb[4] = 8'h03; fb[5] = 8'h04;
    fb[6] = 8'h05; fb[7] = 8'h06; fb[8] = 8'h07; fb[9] = 8'h08;
    send_frame(10);
    tick(); tick();
    checks++; if ({dn1, wc1} !== {1'b1, 16'd2}) begin errors++;
      $display("FAIL wrap_done: got %b/%h want 1/0002", dn1, wc1); end
    checks++; if (log1_n - base !== 2) begin errors++;
      $display("FAIL wrap_nwrites: got %0d want 2", log1_n - base); end
    checks++; if ({log1_a[base], log1_d[base]} !== {16'hFFFF, 32'h04030201}) begin errors++;
      $display("FAIL wrap_w0: got %h/%h want ffff/04030201", log1_a[base], log1_d[base]); end
    checks++; if ({log1_a[base+1], log1_d[base+1]} !== {16'h0000, 32'h08070605}) begin errors++;
      $display("FAIL wrap_w1: got %h/%h want 0000/08070605", log1_a[base+1], log1_d[base+1]); end
  endtask

  task automatic test_timeout();
    base = log0_n;
    pulse_start(0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    repeat (98) tick();
    checks++; if ({b0, e0} !== 2'b10) begin errors++;
      $display("FAIL tmo_early: got %b want 10", {b0, e0}); end
    repeat (3) tick();
    checks++; if ({b0, dn0, e0} !== 3'b001) begin errors++;
      $display("FAIL tmo_abort: got %b want 001", {b0, dn0, e0}); end
    checks++; if (log0_n - base !== 0) begin errors++;
      $display("FAIL tmo_nwrites: got %0d want 0", log0_n - base); end
    pulse_start(0);
    checks++; if ({b0, e0} !== 2'b10) begin errors++;
      $display("FAIL tmo_restart: got %b want 10", {b0, e0}); end
    fb[0] = 8'h00; fb[1] = 8'h00;
    send_frame(2);
    checks++; if (dn0 !== 1'b1) begin errors++;
      $display("FAIL tmo_recover: got %b want 1", dn0); end
    tick();
  endtask

  task automatic test_reset_mid();
    pulse_start(0);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    clrn = 1'b0;
    #1;
    checks++; if ({b0, dn0, e0, w0, a0, d0, wc0} !== 68'h0) begin errors++;
      $display("FAIL rstmid_zero: got %h want 0", {b0, dn0, e0, w0, a0, d0, wc0}); end
    tick();
    clrn = 1'b1;
    tick();
    base = log0_n;
    pulse_start(0);
    fb[0] = 8'h01; fb[1] = 8'h00;
    fb[2] = 8'hAA; fb[3] = 8'hBB; fb[4] = 8'hCC; fb[5] = 8'hDD;
    send_frame(6);
    tick(); tick();
    checks++; if ({dn0, wc0} !== {1'b1, 16'd1}) begin errors++;
      $display("FAIL rstmid_done: got %b/%h want 1/0001", dn0, wc0); end
    checks++; if (log0_n - base !== 1 || {log0_a[base], log0_d[base]} !== {16'h0000, 32'hDDCCBBAA}) begin errors++;
      $display("FAIL rstmid_write: got n=%0d %h/%h want n=1 0000/ddccbbaa", log0_n - base, log0_a[base], log0_d[base]); end
  endtask

  task automatic test_start_ignored();
    logic [7:0] x;
    base = log0_n;
    pulse_start(0);
    fb[0] = 8'h02; fb[1] = 8'h00;
    fb[2] = 8'h01; fb[3] = 8'h02; fb[4] = 8'h03; fb[5] = 8'h04;
    fb[6] = 8'h05; fb[7] = 8'h06; fb[8] = 8'h07; fb[9] = 8'h08;
    x = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) start0 = 1'b1;
      send_byte(fb[i]);
      start0 = 1'b0;
      x = x ^ fb[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x);
`endif
    tick(); tick();
    checks++; if ({dn0, wc0} !== {1'b1, 16'd2}) begin errors++;
      $display("FAIL startign_done: got %b/%h want 1/0002", dn0, wc0); end
    checks++; if (log0_n - base !== 2 || log0_a[base+1] !== 16'h0001 || log0_d[base+1] !== 32'h08070605) begin errors++;
      $display("FAIL startign_writes: got n=%0d %h/%h want n=2 0001/08070605", log0_n - base, log0_a[base+1], log0_d[base+1]); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start(0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h45);
    checks++; if ({b0, dn0, e0} !== 3'b010) begin errors++;
      $display("FAIL chk_good: got %b want 010", {b0, dn0, e0}); end
    tick();
    base = log0_n;
    pulse_start(0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h00);
    checks++; if ({b0, dn0, e0} !== 3'b001) begin errors++;
      $display("FAIL chk_bad: got %b want 001", {b0, dn0, e0}); end
    tick();
    checks++; if (log0_n - base !== 1 || {log0_a[base], log0_d[base]} !== {16'h0000, 32'h44332211}) begin errors++;
      $display("FAIL chk_bad_write: got n=%0d %h/%h want n=1 0000/44332211", log0_n - base, log0_a[base], log0_d[base]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
